// File: rtl/core_cap_pkg.sv
// Shared types and defaults for the core output capture block.
package core_cap_pkg;
  localparam int DEF_DATA_W = 10;
  localparam int DROP_W     = 8;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} cap_state_e;
endpackage

// File: rtl/core_cap_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one wrap bit above the address.
module core_cap_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW:0]                  wptr, rptr;
  logic                         wr_en, rd_en;

  assign level = wptr - rptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[AW-1:0]];

  // A pop frees the head slot in the same edge, so push-while-full is legal then.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + (AW+1)'(1);
      end
      if (rd_en) rptr <= rptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/core_out_capture.sv
// Samples the core output bus, qualifies stable runs, queues new values and
// accounts for samples dropped on a full queue.
module core_out_capture
  import core_cap_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8,
  parameter int STABLE = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      core_out,
  input  logic                   cap_en,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  input  logic                   clr_ovf
);
  localparam int CW = $clog2(STABLE+1);
  localparam logic [CW-1:0] STB = CW'(STABLE);

  logic [DATA_W-1:0] in_q, last_cap;
  logic [CW-1:0]     cnt;
  logic              have_last, changed, run_done, cap, full, empty, pop, drop;
  cap_state_e        state, nxt;

  assign changed  = (core_out != in_q);
  // A run that ends on this very edge is still too short to count.
  assign run_done = (cnt == STB) && !changed;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q <= '0;
      cnt  <= '0;
    end else begin
      in_q <= core_out;
      if (changed)         cnt <= CW'(1);
      else if (cnt != STB) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    cap = 1'b0;
    if (!cap_en) nxt = IDLE;
    else begin
      case (state)
        IDLE:  nxt = TRACK;
        TRACK: if (run_done) begin
          nxt = HOLD;
          cap = !have_last || (in_q != last_cap);
        end
        HOLD:  if (changed) nxt = TRACK;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_cap  <= '0;
      have_last <= 1'b0;
    end else if (state == IDLE) begin
      have_last <= 1'b0;
    end else if (cap) begin
      last_cap  <= in_q;
      have_last <= 1'b1;
    end
  end

  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign drop     = cap && full && !pop;

  core_cap_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (cap),
    .pop   (pop),
    .wdata (in_q),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // A clear coinciding with a drop restarts the count at that drop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      overflow <= drop;
      drop_cnt <= drop ? DROP_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end
endmodule

// File: tb/tb_core_out_capture.sv
// Table-driven bench with a pop-side scoreboard for core_out_capture.
module tb_core_out_capture;
  localparam int DW = 10, DEPTH = 8, STABLE = 2;

  logic          clk = 1'b0, reset = 1'b0;
  logic [DW-1:0] core_out = '0;
  logic          cap_en = 1'b0, rd_ready = 1'b0, clr_ovf = 1'b0;
  logic          rd_valid, overflow;
  logic [DW-1:0] rd_data;
  logic [3:0]    level;
  logic [7:0]    drop_cnt;

  int            n_cmp = 0, n_bad = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [DW-1:0] val;
    logic          en;
    int            cycles;
    logic          push;
  } vec_t;
  vec_t vecs[8];

  core_out_capture #(.DATA_W(DW), .DEPTH(DEPTH), .STABLE(STABLE)) dut (
    .clk      (clk),
    .reset    (reset),
    .core_out (core_out),
    .cap_en   (cap_en),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_valid"}, 32'(rd_valid), 0);
    chk({nm, "_rd_data"},  32'(rd_data),  0);
    chk({nm, "_level"},    32'(level),    0);
    chk({nm, "_overflow"}, 32'(overflow), 0);
    chk({nm, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  // Scoreboard: every accepted pop must match the oldest expected capture.
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got %0h want none", rd_data);
      end else begin
        chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl;
    vecs[0] = '{10'h0AA, 1'b1, 1, 1'b0};
    vecs[1] = '{10'h155, 1'b1, 4, 1'b0};
    vecs[2] = '{10'h0AA, 1'b1, 4, 1'b1};
    vecs[3] = '{10'h100, 1'b1, 4, 1'b1};
    vecs[4] = '{10'h101, 1'b1, 4, 1'b1};
    vecs[5] = '{10'h100, 1'b1, 4, 1'b1};
    vecs[6] = '{10'h100, 1'b0, 2, 1'b0};
    vecs[7] = '{10'h100, 1'b1, 4, 1'b1};

    // Reset and first capture latency
    core_out = 10'h155;
    cyc(5);
    chk_zero("reset");
    reset  = 1'b1;
    cap_en = 1'b1;
    cyc(2);
    chk("lat_early_valid", 32'(rd_valid), 0);
    cyc(1);
    exp_q.push_back(10'h155);
    chk("lat_valid", 32'(rd_valid), 1);
    chk("lat_data",  32'(rd_data),  32'h155);
    chk("lat_level", 32'(level),    1);
    cyc(2);
    lvl = 1;

    for (int i = 0; i < 8; i++) begin
      core_out = vecs[i].val;
      cap_en   = vecs[i].en;
      cyc(vecs[i].cycles);
      if (vecs[i].push) begin
        exp_q.push_back(vecs[i].val);
        lvl++;
      end
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(lvl));
    end

    // Drain through the scoreboard
    rd_ready = 1'b1;
    begin
      int t = 0;
      while (exp_q.size() > 0 && t < 40) begin
        cyc(1);
        t++;
      end
      chk("drain_left", 32'(exp_q.size()), 0);
    end
    rd_ready = 1'b0;
    cyc(1);
    chk("drain_level", 32'(level),    0);
    chk("drain_valid", 32'(rd_valid), 0);

    // Overflow: ten distinct values into eight slots
    for (int i = 0; i < 10; i++) begin
      core_out = DW'(10'h200 + i);
      cyc(4);
      if (i < 8) exp_q.push_back(DW'(10'h200 + i));
      chk($sformatf("ovf%0d_drop", i), 32'(drop_cnt), (i < 8) ? 0 : 32'(i - 7));
    end
    chk("ovf_level", 32'(level),    8);
    chk("ovf_flag",  32'(overflow), 1);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("clr_flag",  32'(overflow), 0);
    chk("clr_drop",  32'(drop_cnt), 0);
    chk("clr_level", 32'(level),    8);

    // Full: push and pop on the same edge
    core_out = 10'h3FF;
    cyc(2);
    rd_ready = 1'b1;
    cyc(1);
    rd_ready = 1'b0;
    exp_q.push_back(10'h3FF);
    chk("pp_level", 32'(level),    8);
    chk("pp_flag",  32'(overflow), 0);
    chk("pp_drop",  32'(drop_cnt), 0);
    chk("pp_head",  32'(rd_data),  32'h201);
    cyc(2);

    // Drop, then clear coinciding with another drop
    core_out = 10'h2AB;
    cyc(4);
    chk("drop1_cnt", 32'(drop_cnt), 1);
    core_out = 10'h2AC;
    cyc(2);
    clr_ovf = 1'b1;
    cyc(1);
    clr_ovf = 1'b0;
    chk("clrdrop_flag", 32'(overflow), 1);
    chk("clrdrop_cnt",  32'(drop_cnt), 1);
    cyc(2);

    // Async reset with five entries queued
    rd_ready = 1'b1;
    cyc(3);
    rd_ready = 1'b0;
    chk("pre_rst_level", 32'(level), 5);
    #2;
    reset = 1'b0;
    #1;
    chk_zero("async_rst");
    exp_q.delete();
    core_out = 10'h0F0;
    cap_en   = 1'b1;
    cyc(2);
    reset    = 1'b1;
    rd_ready = 1'b1;
    exp_q.push_back(10'h0F0);
    cyc(8);
    chk("post_rst_left",  32'(exp_q.size()), 0);
    chk("post_rst_level", 32'(level),        0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
